if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 tb/tb_if_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetcher with a hazard
// stall (freeze), single-cycle branch redirect and a registered output stage.
module if_fetch_unit #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic [WORD_WIDTH-1:0] instruction_out,
    output logic                  fetch_valid,
    output logic [1:0]            dbg_state
);

    // Handshake: imem_req is accepted in the cycle it is high; imem_ready
    // marks imem_rdata valid for the single outstanding request, one or
    // more cycles later. fetch_valid qualifies pc_out/instruction_out until
    // a cycle with freeze=0 consumes them.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(4);

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] pc_out_q, pc_out_d;
    logic [WORD_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  req_c;
    logic [WORD_WIDTH-1:0] pc_plus4;

    assign pc_plus4 = pc_q + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        req_c    = 1'b0;

        case (state_q)
            ST_REQ: begin
                req_c   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_ready) begin
                    pc_out_d = pc_plus4;
                    instr_d  = imem_rdata;
                    valid_d  = 1'b1;
                    pc_d     = pc_plus4;
                    state_d  = ST_VALID;
                end
            end
            ST_VALID: begin
                // Consuming the presented word and fetching the next one
                // happen in the same cycle.
                if (!freeze) begin
                    req_c    = 1'b1;
                    pc_out_d = '0;
                    instr_d  = '0;
                    valid_d  = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_ready) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // A redirect beats everything, including freeze. A response still in
        // flight must be drained in DROP before the new target is requested.
        if (branch_taken) begin
            req_c    = 1'b0;
            pc_d     = branch_addr;
            pc_out_d = '0;
            instr_d  = '0;
            valid_d  = 1'b0;
            if ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_ready) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    assign imem_req        = req_c;
    assign imem_addr       = pc_q;
    assign pc_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign fetch_valid     = valid_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a latency-programmable memory
// responder, a presentation monitor fed by an expected queue, and scenarios.
module tb_if_fetch_unit;

  localparam int W = 32;
  localparam logic [1:0] S_REQ = 2'd0, S_WAIT = 2'd1, S_VALID = 2'd2, S_DROP = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic freeze = 1'b0;
  logic branch_taken = 1'b0;
  logic [W-1:0] branch_addr = '0;
  logic imem_req;
  logic [W-1:0] imem_addr;
  logic imem_ready = 1'b0;
  logic [W-1:0] imem_rdata = '0;
  logic [W-1:0] pc_out;
  logic [W-1:0] instruction_out;
  logic fetch_valid;
  logic [1:0] dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [W-1:0] exp_pc_q[$];
  logic [W-1:0] exp_q[$];

  int mem_latency = 1;
  logic [W-1:0] mem_word = 32'hE3A01005;
  logic stray = 1'b0;
  int cnt = 0;
  logic [W-1:0] pdata = '0;
  logic prev_valid = 1'b0;

  if_fetch_unit #(.WORD_WIDTH(W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .instruction_out(instruction_out), .fetch_valid(fetch_valid),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory responder: requests seen at negedge are accepted at the next
  // posedge; imem_ready rises mem_latency cycles after acceptance
  always @(negedge clk) begin
    if (rst) begin
      cnt = 0;
      imem_ready = 1'b0;
    end else begin
      imem_ready = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_ready = 1'b1;
          imem_rdata = pdata;
        end
      end
      if (stray) begin
        imem_ready = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        stray = 1'b0;
      end
      if (imem_req) begin
        cnt = mem_latency;
        pdata = mem_word;
      end
    end
  end

  // scoreboard: each new presentation pops one expected entry
  always @(negedge clk) begin
    if (fetch_valid && !prev_valid) begin
      total_cnt++;
      if (exp_pc_q.size() == 0) begin
        $display("FAIL unexpected_presentation: pc_out=%h instr=%h, none expected", pc_out, instruction_out);
      end else begin
        logic [W-1:0] epc, eins;
        epc = exp_pc_q.pop_front();
        eins = exp_q.pop_front();
        if (pc_out !== epc || instruction_out !== eins)
          $display("FAIL presentation: pc_out=%h instr=%h, expected pc_out=%h instr=%h", pc_out, instruction_out, epc, eins);
        else pass_cnt++;
      end
    end
    prev_valid = fetch_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++;
    if (pc_out !== 0 || instruction_out !== 0 || fetch_valid !== 0)
      $display("FAIL reset_outputs: pc_out=%h instr=%h valid=%b, expected all 0", pc_out, instruction_out, fetch_valid);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== S_REQ || imem_addr !== 32'h0)
      $display("FAIL reset_state: state=%0d addr=%h, expected 0/0", dbg_state, imem_addr);
    else pass_cnt++;
    tick();
    rst = 1'b0;
  endtask

  // c0: REQ at 0 ... alternating request cycles at 0,4,8
  task automatic test_stream();
    mem_latency = 1;
    mem_word = 32'hE3A01005;
    exp_pc_q.push_back(32'h4);  exp_q.push_back(32'hE3A01005);
    exp_pc_q.push_back(32'h8);  exp_q.push_back(32'hE3A01005);
    exp_pc_q.push_back(32'hC);  exp_q.push_back(32'hE3A01005);
    #1;
    total_cnt++;
    if (imem_req !== 1 || imem_addr !== 32'h0)
      $display("FAIL stream_req0: req=%b addr=%h, expected 1/0", imem_req, imem_addr);
    else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (imem_req !== 0 || dbg_state !== S_WAIT)
      $display("FAIL stream_wait: req=%b state=%0d, expected 0/WAIT", imem_req, dbg_state);
    else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (imem_req !== 1 || imem_addr !== 32'h4 || fetch_valid !== 1)
      $display("FAIL stream_req4: req=%b addr=%h valid=%b, expected 1/4/1", imem_req, imem_addr, fetch_valid);
    else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (fetch_valid !== 0 || instruction_out !== 0 || pc_out !== 0)
      $display("FAIL stream_consumed: valid=%b instr=%h pc_out=%h, expected 0/0/0", fetch_valid, instruction_out, pc_out);
    else pass_cnt++;
    tick();
  endtask

  // entered in VALID with pc_out=8
  task automatic test_freeze();
    for (int i = 0; i < 3; i++) begin
      freeze = 1'b1;
      #1;
      total_cnt++;
      if (imem_req !== 0 || fetch_valid !== 1 || pc_out !== 32'h8 || instruction_out !== 32'hE3A01005)
        $display("FAIL freeze_hold%0d: req=%b valid=%b pc_out=%h instr=%h, expected 0/1/8/e3a01005", i, imem_req, fetch_valid, pc_out, instruction_out);
      else pass_cnt++;
      tick();
    end
    freeze = 1'b0;
    #1;
    total_cnt++;
    if (imem_req !== 1 || imem_addr !== 32'h8)
      $display("FAIL freeze_release: req=%b addr=%h, expected 1/8", imem_req, imem_addr);
    else pass_cnt++;
    tick();
    tick();
  endtask

  // entered in VALID with pc=12
  task automatic test_branch_drop();
    mem_latency = 3;
    tick();
    branch_taken = 1'b1;
    branch_addr = 32'h100;
    #1;
    total_cnt++;
    if (imem_req !== 0)
      $display("FAIL drop_branch_req: req=%b, expected 0", imem_req);
    else pass_cnt++;
    tick();
    branch_taken = 1'b0;
    mem_latency = 1;
    #1;
    total_cnt++;
    if (dbg_state !== S_DROP || fetch_valid !== 0)
      $display("FAIL drop_state: state=%0d valid=%b, expected DROP/0", dbg_state, fetch_valid);
    else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (dbg_state !== S_DROP || imem_req !== 0)
      $display("FAIL drop_still: state=%0d req=%b, expected DROP/0", dbg_state, imem_req);
    else pass_cnt++;
    tick(); #1;
    exp_pc_q.push_back(32'h104); exp_q.push_back(mem_word);
    total_cnt++;
    if (dbg_state !== S_REQ || imem_req !== 1 || imem_addr !== 32'h100)
      $display("FAIL drop_redirect: state=%0d req=%b addr=%h, expected REQ/1/100", dbg_state, imem_req, imem_addr);
    else pass_cnt++;
    tick();
    tick();
  endtask

  // entered in VALID with pc_out=0x104
  task automatic test_branch_freeze();
    branch_taken = 1'b1;
    freeze = 1'b1;
    branch_addr = 32'h200;
    #1;
    total_cnt++;
    if (imem_req !== 0)
      $display("FAIL brfrz_req: req=%b, expected 0", imem_req);
    else pass_cnt++;
    tick();
    branch_taken = 1'b0;
    freeze = 1'b0;
    #1;
    exp_pc_q.push_back(32'h204); exp_q.push_back(mem_word);
    total_cnt++;
    if (fetch_valid !== 0 || instruction_out !== 0 || pc_out !== 0 || imem_req !== 1 || imem_addr !== 32'h200)
      $display("FAIL brfrz_next: valid=%b instr=%h pc_out=%h req=%b addr=%h, expected 0/0/0/1/200", fetch_valid, instruction_out, pc_out, imem_req, imem_addr);
    else pass_cnt++;
    tick();
    tick();
  endtask

  // entered in VALID
  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_addr = 32'hFFFFFFFC;
    tick();
    branch_taken = 1'b0;
    #1;
    exp_pc_q.push_back(32'h0); exp_q.push_back(mem_word);
    total_cnt++;
    if (imem_addr !== 32'hFFFFFFFC || imem_req !== 1)
      $display("FAIL wrap_req: req=%b addr=%h, expected 1/fffffffc", imem_req, imem_addr);
    else pass_cnt++;
    tick();
    tick();
    mem_latency = 3;
    #1;
    total_cnt++;
    if (fetch_valid !== 1 || pc_out !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1)
      $display("FAIL wrap_result: valid=%b pc_out=%h addr=%h req=%b, expected 1/0/0/1", fetch_valid, pc_out, imem_addr, imem_req);
    else pass_cnt++;
    tick();
  endtask

  // entered in WAIT with a slow response outstanding
  task automatic test_reset_mid_wait();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (dbg_state !== S_REQ || fetch_valid !== 0 || pc_out !== 0 || instruction_out !== 0 || imem_addr !== 32'h0)
      $display("FAIL async_reset: state=%0d valid=%b pc_out=%h instr=%h addr=%h, expected REQ/0/0/0/0", dbg_state, fetch_valid, pc_out, instruction_out, imem_addr);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    mem_latency = 1;
    stray = 1'b1;
    exp_pc_q.push_back(32'h4); exp_q.push_back(mem_word);
    #1;
    total_cnt++;
    if (imem_req !== 1 || imem_addr !== 32'h0)
      $display("FAIL post_reset_req: req=%b addr=%h, expected 1/0", imem_req, imem_addr);
    else pass_cnt++;
    tick(); #1;
    total_cnt++;
    if (dbg_state !== S_WAIT || fetch_valid !== 0 || instruction_out !== 0)
      $display("FAIL stray_ignored: state=%0d valid=%b instr=%h, expected WAIT/0/0", dbg_state, fetch_valid, instruction_out);
    else pass_cnt++;
    tick();
  endtask

  // back-to-back fetches with random stalls, latencies and data
  task automatic test_back_to_back();
    logic [W-1:0] pc;
    int n;
    pc = 32'h4;
    for (int i = 0; i < 12; i++) begin
      for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
        freeze = 1'b1;
        #1;
        total_cnt++;
        if (imem_req !== 0 || fetch_valid !== 1)
          $display("FAIL b2b_freeze%0d: req=%b valid=%b, expected 0/1", i, imem_req, fetch_valid);
        else pass_cnt++;
        tick();
      end
      freeze = 1'b0;
      mem_latency = $urandom_range(1, 3);
      mem_word = $urandom;
      exp_pc_q.push_back(pc + 32'h4); exp_q.push_back(mem_word);
      #1;
      total_cnt++;
      if (imem_req !== 1 || imem_addr !== pc)
        $display("FAIL b2b_req%0d: req=%b addr=%h, expected 1/%h", i, imem_req, imem_addr, pc);
      else pass_cnt++;
      pc = pc + 32'h4;
      tick();
      n = 0;
      while (fetch_valid !== 1'b1 && n < 8) begin
        freeze = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      total_cnt++;
      if (fetch_valid !== 1'b1)
        $display("FAIL b2b_timeout%0d: valid=%b after %0d cycles, expected 1", i, fetch_valid, n);
      else pass_cnt++;
    end
    freeze = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (exp_q.size() !== 0)
      $display("FAIL queue_drained: %0d entries left, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_branch_drop();
    test_branch_freeze();
    test_wrap();
    test_reset_mid_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
